// File: rtl/adpcm_pkg.sv
// Shared ADPCM tables and limits for the 4-bit IMA-style encoder and decoder.
package adpcm_pkg;

  localparam logic [6:0]         IDX_MAX = 7'd88;
  localparam logic signed [15:0] PCM_MAX = 16'sh7fff;
  localparam logic signed [15:0] PCM_MIN = 16'sh8000;

  function automatic logic [14:0] step_tab(input logic [6:0] idx);
    case (idx)
      7'd0:  return 15'd7;     7'd1:  return 15'd8;     7'd2:  return 15'd9;     7'd3:  return 15'd10;
      7'd4:  return 15'd11;    7'd5:  return 15'd12;    7'd6:  return 15'd13;    7'd7:  return 15'd14;
      7'd8:  return 15'd16;    7'd9:  return 15'd17;    7'd10: return 15'd19;    7'd11: return 15'd21;
      7'd12: return 15'd23;    7'd13: return 15'd25;    7'd14: return 15'd28;    7'd15: return 15'd31;
      7'd16: return 15'd34;    7'd17: return 15'd37;    7'd18: return 15'd41;    7'd19: return 15'd45;
      7'd20: return 15'd50;    7'd21: return 15'd55;    7'd22: return 15'd60;    7'd23: return 15'd66;
      7'd24: return 15'd73;    7'd25: return 15'd80;    7'd26: return 15'd88;    7'd27: return 15'd97;
      7'd28: return 15'd107;   7'd29: return 15'd118;   7'd30: return 15'd130;   7'd31: return 15'd143;
      7'd32: return 15'd157;   7'd33: return 15'd173;   7'd34: return 15'd190;   7'd35: return 15'd209;
      7'd36: return 15'd230;   7'd37: return 15'd253;   7'd38: return 15'd279;   7'd39: return 15'd307;
      7'd40: return 15'd337;   7'd41: return 15'd371;   7'd42: return 15'd408;   7'd43: return 15'd449;
      7'd44: return 15'd494;   7'd45: return 15'd544;   7'd46: return 15'd598;   7'd47: return 15'd658;
      7'd48: return 15'd724;   7'd49: return 15'd796;   7'd50: return 15'd876;   7'd51: return 15'd963;
      7'd52: return 15'd1060;  7'd53: return 15'd1166;  7'd54: return 15'd1282;  7'd55: return 15'd1411;
      7'd56: return 15'd1552;  7'd57: return 15'd1707;  7'd58: return 15'd1878;  7'd59: return 15'd2066;
      7'd60: return 15'd2272;  7'd61: return 15'd2499;  7'd62: return 15'd2749;  7'd63: return 15'd3024;
      7'd64: return 15'd3327;  7'd65: return 15'd3660;  7'd66: return 15'd4026;  7'd67: return 15'd4428;
      7'd68: return 15'd4871;  7'd69: return 15'd5358;  7'd70: return 15'd5894;  7'd71: return 15'd6484;
      7'd72: return 15'd7132;  7'd73: return 15'd7845;  7'd74: return 15'd8630;  7'd75: return 15'd9493;
      7'd76: return 15'd10442; 7'd77: return 15'd11487; 7'd78: return 15'd12635; 7'd79: return 15'd13899;
      7'd80: return 15'd15289; 7'd81: return 15'd16818; 7'd82: return 15'd18500; 7'd83: return 15'd20350;
      7'd84: return 15'd22385; 7'd85: return 15'd24623; 7'd86: return 15'd27086; 7'd87: return 15'd29794;
      default: return 15'd32767;
    endcase
  endfunction

  function automatic logic signed [4:0] idx_adj(input logic [2:0] d);
    case (d)
      3'd4:    return 5'sd2;
      3'd5:    return 5'sd4;
      3'd6:    return 5'sd6;
      3'd7:    return 5'sd8;
      default: return -5'sd1;
    endcase
  endfunction

endpackage

// File: rtl/adpcm_dec_core.sv
// Single-nibble ADPCM update: predictor and index step with saturation flags.
// Purely combinational; no handshake of its own.
module adpcm_dec_core
  import adpcm_pkg::*;
(
  input  logic signed [15:0] valpred,
  input  logic [6:0]         index,
  input  logic [14:0]        step,
  input  logic [3:0]         code,
  output logic signed [15:0] p,
  output logic [6:0]         index_next,
  output logic               p_overflow,
  output logic               p_underflow,
  output logic               i_overflow,
  output logic               i_underflow
);

  localparam logic signed [17:0] P_HI = 18'(PCM_MAX);
  localparam logic signed [17:0] P_LO = 18'(PCM_MIN);
  localparam logic signed [8:0]  I_HI = 9'(IDX_MAX);

  logic [16:0]        vpdiff;
  logic signed [17:0] p_full;
  logic signed [17:0] vp_s;
  logic signed [17:0] pv_s;
  logic signed [8:0]  idx_full;

  always_comb begin
    // vpdiff can reach 61436, so it keeps a full 17 bits before the 18-bit signed add
    vpdiff = {5'b0, step[14:3]}
           + (code[2] ? {2'b0, step} : 17'd0)
           + (code[1] ? {3'b0, step[14:1]} : 17'd0)
           + (code[0] ? {4'b0, step[14:2]} : 17'd0);
    vp_s   = $signed({1'b0, vpdiff});
    pv_s   = 18'(valpred);
    p_full = code[3] ? (pv_s - vp_s) : (pv_s + vp_s);

    p_overflow  = (p_full > P_HI);
    p_underflow = (p_full < P_LO);
    p = p_overflow ? PCM_MAX : (p_underflow ? PCM_MIN : p_full[15:0]);

    idx_full    = $signed({2'b0, index}) + 9'(idx_adj(code[2:0]));
    i_underflow = (idx_full < 9'sd0);
    i_overflow  = (idx_full > I_HI);
    index_next  = i_underflow ? 7'd0 : (i_overflow ? IDX_MAX : idx_full[6:0]);
  end

endmodule

// File: rtl/adpcm_dec.sv
// ADPCM decoder: four codes per word, one registered sample per cycle (first sample one cycle after word accept).
// Decoding stalls while an output sample is held by y_ready=0; a header is taken only when no word is in flight.
module adpcm_dec
  import adpcm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               hdr_valid,
  input  logic signed [15:0] hdr_pred,
  input  logic [6:0]         hdr_index,
  output logic               hdr_ready,
  input  logic               code_valid,
  input  logic [15:0]        code_word,
  output logic               code_ready,
  output logic signed [15:0] y_out,
  output logic               y_valid,
  input  logic               y_ready,
  output logic signed [7:0]  i_out,
  output logic [14:0]        sz_out,
  output logic               p_overflow,
  output logic               p_underflow,
  output logic               i_overflow,
  output logic               i_underflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic signed [15:0] valpred;
  logic [6:0]         index;
  logic [14:0]        step;
  logic [15:0]        sreg;
  logic [1:0]         cnt;

  logic signed [15:0] p;
  logic [6:0]         index_next;
  logic               po, pu, io, iu;
  logic               advance, decode, hdr_take, word_take;
  logic [6:0]         hdr_idx;

  adpcm_dec_core u_core (
    .valpred     (valpred),
    .index       (index),
    .step        (step),
    .code        (sreg[3:0]),
    .p           (p),
    .index_next  (index_next),
    .p_overflow  (po),
    .p_underflow (pu),
    .i_overflow  (io),
    .i_underflow (iu)
  );

  // A header beats a simultaneous code word; the next word is pulled in on the last nibble.
  assign advance    = !y_valid || y_ready;
  assign decode     = (state == RUN) && advance;
  assign hdr_ready  = (state == IDLE);
  assign code_ready = (state == IDLE) ? !hdr_valid : ((cnt == 2'd3) && advance);
  assign hdr_take   = hdr_valid && hdr_ready;
  assign word_take  = code_valid && code_ready;
  assign hdr_idx    = (hdr_index > IDX_MAX) ? IDX_MAX : hdr_index;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      valpred     <= '0;
      index       <= '0;
      step        <= '0;
      sreg        <= '0;
      cnt         <= '0;
      y_out       <= '0;
      y_valid     <= 1'b0;
      i_out       <= '0;
      sz_out      <= '0;
      p_overflow  <= 1'b0;
      p_underflow <= 1'b0;
      i_overflow  <= 1'b0;
      i_underflow <= 1'b0;
    end else begin
      if (hdr_take) begin
        valpred <= hdr_pred;
        index   <= hdr_idx;
        step    <= step_tab(hdr_idx);
      end else if (decode) begin
        valpred <= p;
        index   <= index_next;
        step    <= step_tab(index_next);
      end

      if (state == IDLE) begin
        if (word_take) begin
          sreg  <= code_word;
          cnt   <= 2'd0;
          state <= RUN;
        end
      end else if (decode) begin
        if (cnt == 2'd3) begin
          if (word_take) begin
            sreg <= code_word;
            cnt  <= 2'd0;
          end else begin
            state <= IDLE;
          end
        end else begin
          sreg <= sreg >> 4;
          cnt  <= cnt + 2'd1;
        end
      end

      if (decode) begin
        y_out       <= p;
        y_valid     <= 1'b1;
        i_out       <= {1'b0, index_next};
        sz_out      <= step;
        p_overflow  <= po;
        p_underflow <= pu;
        i_overflow  <= io;
        i_underflow <= iu;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adpcm_dec.sv
// Directed-vector bench for adpcm_dec with hand-computed samples checked in order.
module tb_adpcm_dec;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               hdr_valid = 1'b0;
  logic signed [15:0] hdr_pred = '0;
  logic [6:0]         hdr_index = '0;
  logic               hdr_ready;
  logic               code_valid = 1'b0;
  logic [15:0]        code_word = '0;
  logic               code_ready;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               y_ready = 1'b1;
  logic signed [7:0]  i_out;
  logic [14:0]        sz_out;
  logic               p_overflow, p_underflow, i_overflow, i_underflow;

  adpcm_dec dut (
    .clk(clk), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_pred(hdr_pred), .hdr_index(hdr_index), .hdr_ready(hdr_ready),
    .code_valid(code_valid), .code_word(code_word), .code_ready(code_ready),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .i_out(i_out), .sz_out(sz_out),
    .p_overflow(p_overflow), .p_underflow(p_underflow),
    .i_overflow(i_overflow), .i_underflow(i_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         y;
    int         i;
    int         sz;
    logic [3:0] fl;   // {p_overflow, p_underflow, i_overflow, i_underflow}
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, $signed(got), $signed(want));
    end
  endtask

  task automatic push(input int y, input int i, input int sz, input logic [3:0] fl);
    exp_t e;
    e.y = y; e.i = i; e.sz = sz; e.fl = fl;
    q.push_back(e);
  endtask

  // Every presented sample is compared against the next expected one.
  always @(negedge clk) begin
    if (reset && y_valid && y_ready) begin
      if (q.size() == 0) begin
        chk("spurious_sample", 32'(y_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y_out",  32'(y_out),  32'(e.y));
        chk("i_out",  32'(i_out),  32'(e.i));
        chk("sz_out", 32'(sz_out), 32'(e.sz));
        chk("flags",  32'({p_overflow, p_underflow, i_overflow, i_underflow}), 32'(e.fl));
      end
    end
  end

  task automatic send_hdr(input int pred, input int idx);
    bit ok = 1'b0;
    @(posedge clk); #1;
    hdr_valid = 1'b1; hdr_pred = 16'(pred); hdr_index = 7'(idx);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (hdr_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    chk("hdr_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w);
    bit ok = 1'b0;
    @(posedge clk); #1;
    code_valid = 1'b1; code_word = w;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (code_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    code_valid = 1'b0;
    chk("word_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  task automatic scen_zero_word();
    push(0, 0, 0, 4'b0001);
    push(0, 0, 7, 4'b0001);
    push(0, 0, 7, 4'b0001);
    push(0, 0, 7, 4'b0001);
    send_word(16'h0000);
    drain();
  endtask

  task automatic push_1000_0007();
    push(1034, 18, 19, 4'b0000);
    push(1039, 17, 41, 4'b0000);
    push(1043, 16, 37, 4'b0000);
    push(1047, 15, 34, 4'b0000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_y_valid",    32'(y_valid), 32'd0);
    chk("rst_y_out",      32'(y_out), 32'd0);
    chk("rst_i_out",      32'(i_out), 32'd0);
    chk("rst_sz_out",     32'(sz_out), 32'd0);
    chk("rst_flags",      32'({p_overflow, p_underflow, i_overflow, i_underflow}), 32'd0);
    chk("rst_hdr_ready",  32'(hdr_ready), 32'd1);
    chk("rst_code_ready", 32'(code_ready), 32'd1);

    // zero-step start: first sample uses step 0, index pinned at 0
    scen_zero_word();

    send_hdr(1000, 10);
    push_1000_0007();
    send_word(16'h0007);
    drain();

    // positive saturation, then negative swing down to -32768
    send_hdr(32000, 88);
    for (int k = 0; k < 4; k++) push(32767, 88, 32767, 4'b1010);
    send_word(16'h7777);
    drain();
    push(-28669, 88, 32767, 4'b0010);
    for (int k = 0; k < 3; k++) push(-32768, 88, 32767, 4'b0110);
    send_word(16'hFFFF);
    drain();

    // backpressure for three cycles after the first sample
    @(posedge clk); #1 y_ready = 1'b0;
    send_hdr(1000, 10);
    push_1000_0007();
    send_word(16'h0007);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_y_valid",    32'(y_valid), 32'd1);
      chk("stall_y_out",      32'(y_out), 32'd1034);
      chk("stall_i_out",      32'(i_out), 32'd18);
      chk("stall_code_ready", 32'(code_ready), 32'd0);
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    drain();

    // back-to-back words at full rate
    send_hdr(1000, 10);
    push_1000_0007();
    push(1050, 14, 31, 4'b0000);
    push(1053, 13, 28, 4'b0000);
    push(1056, 12, 25, 4'b0000);
    push(1058, 11, 23, 4'b0000);
    code_valid = 1'b1; code_word = 16'h0007;
    @(negedge clk);
    chk("b2b_first_ready", 32'(code_ready), 32'd1);
    @(posedge clk); #1;
    code_word = 16'h0000;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("b2b_y_valid", 32'(y_valid), 32'(k >= 2));
      if (k <= 8) chk("b2b_code_ready", 32'(code_ready), 32'(k == 4 || k == 8));
      @(posedge clk); #1;
      if (k == 4) code_valid = 1'b0;
    end
    drain();

    // header and code together in IDLE; header index 100 clamps to 88
    @(posedge clk); #1;
    hdr_valid = 1'b1; hdr_pred = -16'sd500; hdr_index = 7'd100;
    code_valid = 1'b1; code_word = 16'h0008;
    push(-4595, 87, 32767, 4'b0000);
    push(-871,  86, 29794, 4'b0000);
    push(2514,  85, 27086, 4'b0000);
    push(5591,  84, 24623, 4'b0000);
    @(negedge clk);
    chk("both_hdr_ready",  32'(hdr_ready), 32'd1);
    chk("both_code_ready", 32'(code_ready), 32'd0);
    @(posedge clk); #1 hdr_valid = 1'b0;
    @(negedge clk);
    chk("after_hdr_code_ready", 32'(code_ready), 32'd1);
    @(posedge clk); #1 code_valid = 1'b0;
    drain();

    // reset pulse after two samples of a word
    send_hdr(1000, 10);
    push(1034, 18, 19, 4'b0000);
    push(1039, 17, 41, 4'b0000);
    send_word(16'h0007);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_y_valid",   32'(y_valid), 32'd0);
    chk("midrst_y_out",     32'(y_out), 32'd0);
    chk("midrst_sz_out",    32'(sz_out), 32'd0);
    chk("midrst_hdr_ready", 32'(hdr_ready), 32'd1);
    chk("midrst_consumed",  32'(q.size()), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    scen_zero_word();

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("end_y_valid", 32'(y_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
